ad9361_spi_master: RTL and testbench

//  Converts the single-register bus requests issued by the AD9361 init sequencer
//  (read/write, 10-bit address, 8-bit data, waitrequest) into 24-bit AD9361 4-wire
//  SPI frames. Sits directly downstream of the init sequencer and drives the chip
//  SPI pins. Returns read data to the sequencer for calibration and lock polling.

---
 rtl/ad9361_spi_master.sv | 166 ++++++++++++++++
 tb/tb_ad9361_spi_master.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ad9361_spi_master.sv
// AD9361 SPI master: turns single-register read/write bus requests
// into 24-bit 4-wire SPI frames and returns read data to the sequencer.
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   read, write         level requests (write wins when both are high)
//   address[9:0]        register address
//   writedata[7:0]      byte to write
//   readdata[7:0]       last read result, held until the next read completes
//   waitrequest         high except for the single completion cycle
//   spi_csn             chip select, active low
//   spi_clk             SPI clock, idles low
//   spi_mosi            serial data to chip, MSB first
//   spi_miso            serial data from chip
module ad9361_spi_master #(
  parameter int CLK_DIV      = 2,
  parameter int CS_SETUP     = 2,
  parameter int CS_HOLD      = 2,
  parameter int GUARD_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       read,
  input  logic       write,
  input  logic [9:0] address,
  input  logic [7:0] writedata,
  output logic [7:0] readdata,
  output logic       waitrequest,
  output logic       spi_csn,
  output logic       spi_clk,
  output logic       spi_mosi,
  input  logic       spi_miso
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD,
    S_DONE,
    S_GUARD
  } state_e;

  localparam logic [15:0] SETUP_LAST = 16'(CS_SETUP - 1);
  localparam logic [15:0] HI_FIRST   = 16'(CLK_DIV);
  localparam logic [15:0] BIT_LAST   = 16'(2 * CLK_DIV - 1);
  localparam logic [15:0] HOLD_LAST  = 16'(CS_HOLD - 1);
  localparam logic [15:0] GUARD_LAST = 16'(GUARD_CYCLES - 1);
  localparam logic [4:0]  LAST_BIT   = 5'd23;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [4:0]  bit_q, bit_d;
  logic [23:0] sh_q, sh_d;
  logic [7:0]  rx_q, rx_d;
  logic        rd_q, rd_d;
  logic [7:0]  rdata_q, rdata_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      rx_q    <= '0;
      rd_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      rx_q    <= rx_d;
      rd_q    <= rd_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 16'd1;
    bit_d       = bit_q;
    sh_d        = sh_q;
    rx_d        = rx_q;
    rd_d        = rd_q;
    rdata_d     = rdata_q;
    waitrequest = 1'b1;
    spi_csn     = 1'b1;
    spi_clk     = 1'b0;
    spi_mosi    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (read | write) begin
          // Frame: W, 1-byte count (000), 2'b00, address, data.
          sh_d    = {write, 5'b00000, address,
                     write ? writedata : 8'h00};
          rd_d    = ~write;
          bit_d   = '0;
          state_d = S_SETUP;
        end
      end

      S_SETUP: begin
        spi_csn  = 1'b0;
        spi_mosi = sh_q[23];
        if (cnt_q == SETUP_LAST) begin
          cnt_d   = '0;
          state_d = S_SHIFT;
        end
      end

      S_SHIFT: begin
        spi_csn  = 1'b0;
        spi_mosi = sh_q[23];
        spi_clk  = (cnt_q >= HI_FIRST);
        if (cnt_q == BIT_LAST) begin
          // Last high cycle of the bit: capture MISO, and
          // advance MOSI so it changes just after the fall.
          cnt_d = '0;
          rx_d  = {rx_q[6:0], spi_miso};
          sh_d  = {sh_q[22:0], 1'b0};
          if (bit_q == LAST_BIT) begin
            state_d = S_HOLD;
          end else begin
            bit_d = bit_q + 5'd1;
          end
        end
      end

      S_HOLD: begin
        spi_csn = 1'b0;
        if (cnt_q == HOLD_LAST) begin
          cnt_d   = '0;
          state_d = S_DONE;
          // Load here so readdata is already valid in the
          // completion cycle.
          if (rd_q) begin
            rdata_d = rx_q;
          end
        end
      end

      S_DONE: begin
        waitrequest = 1'b0;
        cnt_d       = '0;
        state_d     = S_GUARD;
      end

      S_GUARD: begin
        if (cnt_q == GUARD_LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign readdata = rdata_q;

endmodule

// File: tb/tb_ad9361_spi_master.sv
// Testbench for ad9361_spi_master: scoreboard of expected SPI frames
// and readdata, checked against a pin-level monitor.
module tb_ad9361_spi_master;

  localparam int GUARD = 8;
  localparam int LEN0  = 2 + 48 * 2 + 2;
  localparam int LEN1  = 1 + 48 * 1 + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       read = 1'b0;
  logic       write = 1'b0;
  logic [9:0] address = '0;
  logic [7:0] writedata = '0;
  logic [7:0] readdata;
  logic       waitrequest;
  logic       spi_csn;
  logic       spi_clk;
  logic       spi_mosi;
  logic       spi_miso = 1'b0;

  logic       rd1 = 1'b0;
  logic       wr1 = 1'b0;
  logic [7:0] readdata1;
  logic       wait1;
  logic       csn1;
  logic       sclk1;
  logic       mosi1;
  logic       miso1 = 1'b0;

  int ntests = 0;
  int nfail  = 0;

  logic [7:0]  miso_val = '0;
  logic [7:0]  rd_model = '0;

  logic [23:0] exp_frame_q[$];
  logic [7:0]  exp_rd_q[$];
  logic [23:0] obs_frame_q[$];
  int          obs_len_q[$];
  int          obs_rises_q[$];
  logic [7:0]  obs_rd_q[$];
  int          obs_gap_q[$];

  int          mon_len = 0;
  int          mon_rises = 0;
  logic [23:0] mon_cap = '0;
  logic        csn_prev = 1'b1;
  logic        sclk_prev = 1'b0;
  int          wr_lows = 0;

  always #5 clk = ~clk;

  ad9361_spi_master #(
    .CLK_DIV(2), .CS_SETUP(2), .CS_HOLD(2), .GUARD_CYCLES(GUARD)
  ) dut (
    .clk(clk), .rst(rst), .read(read), .write(write),
    .address(address), .writedata(writedata),
    .readdata(readdata), .waitrequest(waitrequest),
    .spi_csn(spi_csn), .spi_clk(spi_clk),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso)
  );

  ad9361_spi_master #(
    .CLK_DIV(1), .CS_SETUP(1), .CS_HOLD(1), .GUARD_CYCLES(GUARD)
  ) dut1 (
    .clk(clk), .rst(rst), .read(rd1), .write(wr1),
    .address(address), .writedata(writedata),
    .readdata(readdata1), .waitrequest(wait1),
    .spi_csn(csn1), .spi_clk(sclk1),
    .spi_mosi(mosi1), .spi_miso(miso1)
  );

  // Pin monitor and chip model: values read here are the ones
  // present during the cycle that this edge closes.
  always @(posedge clk) begin
    if (!spi_csn) begin
      if (csn_prev) begin
        mon_len   = 1;
        mon_rises = 0;
        mon_cap   = '0;
      end else begin
        mon_len++;
      end
    end
    if (spi_clk && !sclk_prev) begin
      mon_cap = {mon_cap[22:0], spi_mosi};
      mon_rises++;
      if (mon_rises >= 17 && mon_rises <= 24)
        spi_miso <= miso_val[24 - mon_rises];
      else
        spi_miso <= 1'b0;
    end
    if (spi_csn && !csn_prev) begin
      obs_frame_q.push_back(mon_cap);
      obs_len_q.push_back(mon_len);
      obs_rises_q.push_back(mon_rises);
    end
    if (!waitrequest) begin
      wr_lows++;
      obs_rd_q.push_back(readdata);
      obs_gap_q.push_back((!csn_prev && spi_csn) ? 1 : 0);
    end
    csn_prev  = spi_csn;
    sclk_prev = spi_clk;
  end

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    ntests++;
    if (readdata !== 8'h00) begin
      nfail++;
      $display("FAIL reset_readdata: got %h want 00", readdata);
    end
    ntests++;
    if (waitrequest !== 1'b1) begin
      nfail++;
      $display("FAIL reset_wait: got %b want 1", waitrequest);
    end
    ntests++;
    if (spi_csn !== 1'b1 || csn1 !== 1'b1) begin
      nfail++;
      $display("FAIL reset_csn: got %b/%b want 1/1", spi_csn, csn1);
    end
    ntests++;
    if (spi_clk !== 1'b0 || sclk1 !== 1'b0) begin
      nfail++;
      $display("FAIL reset_sclk: got %b/%b want 0/0", spi_clk, sclk1);
    end
    ntests++;
    if (spi_mosi !== 1'b0) begin
      nfail++;
      $display("FAIL reset_mosi: got %b want 0", spi_mosi);
    end
    obs_frame_q.delete(); obs_len_q.delete(); obs_rises_q.delete();
    obs_rd_q.delete(); obs_gap_q.delete();
  endtask

  task automatic do_req(input logic r, input logic w,
                        input logic [9:0] a, input logic [7:0] d,
                        input logic [7:0] mv, input string nm);
    logic [23:0] ef;
    logic [7:0]  erd;
    int          wl0;
    int          k;
    ef  = {w, 5'b00000, a, w ? d : 8'h00};
    erd = w ? rd_model : mv;
    rd_model = erd;
    exp_frame_q.push_back(ef);
    exp_rd_q.push_back(erd);
    miso_val = mv;
    wl0 = wr_lows;
    @(negedge clk);
    read = r; write = w; address = a; writedata = d;
    k = 0;
    while (spi_csn && k < 20) begin
      @(negedge clk);
      k++;
    end
    ntests++;
    if (k != 1) begin
      nfail++;
      $display("FAIL %s_csn_latency: got %0d want 1", nm, k);
    end
    address   = 10'($urandom);
    writedata = 8'($urandom);
    k = 0;
    while (waitrequest && k < 400) begin
      @(negedge clk);
      k++;
    end
    ntests++;
    if (waitrequest !== 1'b0) begin
      nfail++;
      $display("FAIL %s_timeout: got wait=%b want 0", nm, waitrequest);
      read = 1'b0; write = 1'b0;
      exp_frame_q.delete(); exp_rd_q.delete();
      return;
    end
    ntests++;
    if (readdata !== erd) begin
      nfail++;
      $display("FAIL %s_rd_done: got %h want %h", nm, readdata, erd);
    end
    @(negedge clk);
    read = 1'b0; write = 1'b0;
    repeat (GUARD + 4) @(negedge clk);
    ntests++;
    if (wr_lows - wl0 != 1) begin
      nfail++;
      $display("FAIL %s_wait_pulses: got %0d want 1", nm, wr_lows - wl0);
    end
    ntests++;
    if (readdata !== erd) begin
      nfail++;
      $display("FAIL %s_rd_held: got %h want %h", nm, readdata, erd);
    end
    ef  = exp_frame_q.pop_front();
    erd = exp_rd_q.pop_front();
    ntests++;
    if (obs_frame_q.size() == 0 || obs_rd_q.size() == 0) begin
      nfail++;
      $display("FAIL %s_no_frame: got 0 want 1", nm);
    end else begin
      if (obs_frame_q[0] !== ef) begin
        nfail++;
        $display("FAIL %s_mosi: got %h want %h", nm, obs_frame_q[0], ef);
      end
      ntests++;
      if (obs_len_q[0] != LEN0 || obs_rises_q[0] != 24) begin
        nfail++;
        $display("FAIL %s_len: got %0d/%0d want %0d/24", nm,
                 obs_len_q[0], obs_rises_q[0], LEN0);
      end
      ntests++;
      if (obs_gap_q[0] != 1 || obs_rd_q[0] !== erd) begin
        nfail++;
        $display("FAIL %s_done: got gap=%0d rd=%h want gap=1 rd=%h", nm,
                 obs_gap_q[0], obs_rd_q[0], erd);
      end
    end
    obs_frame_q.delete(); obs_len_q.delete(); obs_rises_q.delete();
    obs_rd_q.delete(); obs_gap_q.delete();
  endtask

  task automatic test_write;
    do_req(1'b0, 1'b1, 10'h3DF, 8'h01, 8'hFF, "write");
  endtask

  task automatic test_read;
    do_req(1'b1, 1'b0, 10'h037, 8'hEE, 8'h08, "read");
  endtask

  task automatic test_rw_both;
    do_req(1'b1, 1'b1, 10'h016, 8'h80, 8'h3C, "rw_both");
  endtask

  task automatic test_repeat_poll;
    int          wl0;
    int          k;
    logic [23:0] ef;
    miso_val = 8'hA5;
    rd_model = 8'hA5;
    wl0 = wr_lows;
    ef  = 24'h01AB00;
    exp_frame_q.push_back(ef);
    exp_frame_q.push_back(ef);
    @(negedge clk);
    read = 1'b1; address = 10'h1AB;
    k = 0;
    while (spi_csn && k < 20) begin @(negedge clk); k++; end
    k = 0;
    while (!spi_csn && k < 300) begin @(negedge clk); k++; end
    k = 0;
    while (spi_csn && k < 50) begin k++; @(negedge clk); end
    ntests++;
    if (k != GUARD + 2) begin
      nfail++;
      $display("FAIL poll_gap: got %0d want %0d", k, GUARD + 2);
    end
    ntests++;
    if (wr_lows - wl0 != 1) begin
      nfail++;
      $display("FAIL poll_first_pulse: got %0d want 1", wr_lows - wl0);
    end
    k = 0;
    while (waitrequest && k < 400) begin @(negedge clk); k++; end
    @(negedge clk);
    read = 1'b0;
    repeat (GUARD + 4) @(negedge clk);
    ntests++;
    if (wr_lows - wl0 != 2) begin
      nfail++;
      $display("FAIL poll_pulses: got %0d want 2", wr_lows - wl0);
    end
    for (int i = 0; i < 2; i++) begin
      ef = exp_frame_q.pop_front();
      ntests++;
      if (obs_frame_q.size() == 0) begin
        nfail++;
        $display("FAIL poll_frame%0d: got none want %h", i, ef);
      end else if (obs_frame_q[0] !== ef || obs_len_q[0] != LEN0) begin
        nfail++;
        $display("FAIL poll_frame%0d: got %h/%0d want %h/%0d", i,
                 obs_frame_q[0], obs_len_q[0], ef, LEN0);
      end
      if (obs_frame_q.size() != 0) begin
        void'(obs_frame_q.pop_front());
        void'(obs_len_q.pop_front());
        void'(obs_rises_q.pop_front());
      end
    end
    ntests++;
    if (readdata !== 8'hA5) begin
      nfail++;
      $display("FAIL poll_readdata: got %h want a5", readdata);
    end
    obs_frame_q.delete(); obs_len_q.delete(); obs_rises_q.delete();
    obs_rd_q.delete(); obs_gap_q.delete();
  endtask

  task automatic test_reset_mid;
    int wl0;
    int k;
    wl0 = wr_lows;
    @(negedge clk);
    write = 1'b1; address = 10'h2F0; writedata = 8'hC3;
    k = 0;
    while (mon_rises != 11 && k < 200) begin
      @(negedge clk);
      k++;
      if (!spi_csn) write = 1'b0;
    end
    write = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    ntests++;
    if (spi_csn !== 1'b1 || spi_clk !== 1'b0) begin
      nfail++;
      $display("FAIL abort_pins: got csn=%b clk=%b want 1/0", spi_csn, spi_clk);
    end
    rst = 1'b0;
    rd_model = 8'h00;
    repeat (30) @(negedge clk);
    ntests++;
    if (wr_lows != wl0) begin
      nfail++;
      $display("FAIL abort_pulse: got %0d want 0", wr_lows - wl0);
    end
    ntests++;
    if (obs_len_q.size() != 1 || obs_len_q[0] >= LEN0) begin
      nfail++;
      $display("FAIL abort_partial: got %0d frames want 1 short", obs_len_q.size());
    end
    obs_frame_q.delete(); obs_len_q.delete(); obs_rises_q.delete();
    obs_rd_q.delete(); obs_gap_q.delete();
    do_req(1'b0, 1'b1, 10'h123, 8'h5A, 8'h00, "post_abort");
  endtask

  task automatic test_clkdiv1;
    int          lows;
    int          rises;
    int          falls;
    int          wls;
    logic [23:0] cap;
    logic        pc;
    logic        ps;
    lows = 0; rises = 0; falls = 0; wls = 0;
    cap = '0; pc = 1'b1; ps = 1'b0;
    @(negedge clk);
    address = 10'h2AA; writedata = 8'h55; wr1 = 1'b1;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (!csn1) lows++;
      if (!csn1 && pc) falls++;
      if (sclk1 && !ps) begin
        rises++;
        cap = {cap[22:0], mosi1};
      end
      if (!wait1) begin
        wls++;
        wr1 = 1'b0;
      end
      pc = csn1;
      ps = sclk1;
    end
    ntests++;
    if (lows != LEN1 || falls != 1) begin
      nfail++;
      $display("FAIL div1_len: got %0d/%0d want %0d/1", lows, falls, LEN1);
    end
    ntests++;
    if (rises != 24) begin
      nfail++;
      $display("FAIL div1_rises: got %0d want 24", rises);
    end
    ntests++;
    if (cap !== 24'h82AA55) begin
      nfail++;
      $display("FAIL div1_mosi: got %h want 82aa55", cap);
    end
    ntests++;
    if (wls != 1) begin
      nfail++;
      $display("FAIL div1_pulses: got %0d want 1", wls);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_repeat_poll();
    test_rw_both();
    test_reset_mid();
    test_clkdiv1();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
